// File: rtl/sa_pkg.sv
// Shared types and width/latency helpers for the parametrised systolic array.
package sa_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sa_state_t;

    // Index width that stays at least one bit for degenerate 1-wide dimensions.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int klen_w(input int k_max);
        return $clog2(k_max + 1);
    endfunction

    function automatic int drain_cycles(input int rows, input int cols);
        return rows + cols - 1;
    endfunction

    function automatic int prod_w(input int dw);
        return 2 * dw + 1;
    endfunction

endpackage

// File: rtl/sa_pe.sv
// One processing element: forwards A right and B down with their valid tags,
// and accumulates the signed or unsigned product when both tags are set.
module sa_pe
    import sa_pkg::*;
#(
    parameter int DW    = 8,
    parameter int ACC_W = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             signed_mode,
    input  logic [DW-1:0]    a_in,
    input  logic             a_v_in,
    input  logic [DW-1:0]    b_in,
    input  logic             b_v_in,
    output logic [DW-1:0]    a_out,
    output logic             a_v_out,
    output logic [DW-1:0]    b_out,
    output logic             b_v_out,
    output logic [ACC_W-1:0] acc
);

    localparam int PW = prod_w(DW);

    logic signed [DW:0]   a_ext;
    logic signed [DW:0]   b_ext;
    logic signed [PW-1:0] prod;

    assign a_ext = {signed_mode & a_in[DW-1], a_in};
    assign b_ext = {signed_mode & b_in[DW-1], b_in};
    assign prod  = PW'(a_ext) * PW'(b_ext);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out   <= '0;
            a_v_out <= 1'b0;
            b_out   <= '0;
            b_v_out <= 1'b0;
            acc     <= '0;
        end else begin
            a_out   <= a_in;
            a_v_out <= a_v_in;
            b_out   <= b_in;
            b_v_out <= b_v_in;
            // Signed cast to ACC_W sign-extends or truncates; the add wraps.
            if (clear)
                acc <= '0;
            else if (a_v_in && b_v_in)
                acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/systolic_array_param.sv
// Output-stationary ROWS x COLS systolic multiplier with internal operand skew,
// valid/ready beat intake, start/busy/done control and a registered read port.
//   state    | meaning
//   ST_IDLE  | waiting for start; result reads allowed
//   ST_LOAD  | accepting K operand beats (in_ready=1)
//   ST_DRAIN | last beat propagating to the far corner PE
//   ST_DONE  | one-cycle done pulse, then back to ST_IDLE
module systolic_array_param
    import sa_pkg::*;
#(
    parameter int ROWS  = 32,
    parameter int COLS  = 32,
    parameter int DW    = 8,
    parameter int K_MAX = 32,
    parameter int ACC_W = 2 * DW + $clog2(K_MAX) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [klen_w(K_MAX)-1:0]  k_len,
    input  logic                      signed_mode,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [ROWS*DW-1:0]        a_col,
    input  logic [COLS*DW-1:0]        b_row,
    output logic                      busy,
    output logic                      done,
    input  logic                      rd_en,
    input  logic [idx_w(ROWS)-1:0]    rd_row,
    input  logic [idx_w(COLS)-1:0]    rd_col,
    output logic                      rd_valid,
    output logic [ACC_W-1:0]          rd_data
);

    localparam int KW    = klen_w(K_MAX);
    localparam int RW    = idx_w(ROWS);
    localparam int CW    = idx_w(COLS);
    localparam int DRAIN = drain_cycles(ROWS, COLS);
    localparam int DCW   = $clog2(DRAIN + 1);

    localparam logic [KW-1:0]  K_MAX_L = KW'(K_MAX);
    localparam logic [DCW-1:0] DRAIN_L = DCW'(DRAIN);
    localparam logic [RW:0]    ROWS_L  = (RW + 1)'(ROWS);
    localparam logic [CW:0]    COLS_L  = (CW + 1)'(COLS);

    sa_state_t      state;
    logic [KW-1:0]  beats_left;
    logic [DCW-1:0] drain_cnt;
    logic           sm_q;
    logic [KW-1:0]  k_eff;
    logic           accept;
    logic           clear;

    assign k_eff  = (k_len > K_MAX_L) ? K_MAX_L : k_len;
    assign accept = in_valid & in_ready;
    assign clear  = (state == ST_IDLE) & start;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            beats_left <= '0;
            drain_cnt  <= '0;
            sm_q       <= 1'b0;
            in_ready   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sm_q       <= signed_mode;
                        beats_left <= k_eff;
                        if (k_eff == '0) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ST_LOAD;
                            in_ready <= 1'b1;
                            busy     <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (beats_left == KW'(1)) begin
                            state     <= ST_DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= DRAIN_L;
                        end else begin
                            beats_left <= beats_left - KW'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    // Terminal count lands one edge after the corner PE's final MAC.
                    if (drain_cnt == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DCW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    logic [DW-1:0]    a_h  [ROWS][COLS+1];
    logic             av_h [ROWS][COLS+1];
    logic [DW-1:0]    b_d  [ROWS+1][COLS];
    logic             bv_d [ROWS+1][COLS];
    logic [ACC_W-1:0] acc  [ROWS][COLS];
    logic [ROWS-1:0]  unused_a;
    logic [COLS-1:0]  unused_b;

    // Lane n passes through n+1 skew registers before entering the edge PE.
    for (genvar i = 0; i < ROWS; i++) begin : g_askew
        logic [DW-1:0] d [0:i];
        logic          v [0:i];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= i; s++) begin
                    d[s] <= '0;
                    v[s] <= 1'b0;
                end
            end else begin
                d[0] <= a_col[DW*i +: DW];
                v[0] <= accept;
                for (int s = 1; s <= i; s++) begin
                    d[s] <= d[s-1];
                    v[s] <= v[s-1];
                end
            end
        end
        assign a_h[i][0]  = d[i];
        assign av_h[i][0] = v[i];
        assign unused_a[i] = ^{av_h[i][COLS], a_h[i][COLS]};
    end

    for (genvar j = 0; j < COLS; j++) begin : g_bskew
        logic [DW-1:0] d [0:j];
        logic          v [0:j];
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                for (int s = 0; s <= j; s++) begin
                    d[s] <= '0;
                    v[s] <= 1'b0;
                end
            end else begin
                d[0] <= b_row[DW*j +: DW];
                v[0] <= accept;
                for (int s = 1; s <= j; s++) begin
                    d[s] <= d[s-1];
                    v[s] <= v[s-1];
                end
            end
        end
        assign b_d[0][j]  = d[j];
        assign bv_d[0][j] = v[j];
        assign unused_b[j] = ^{bv_d[ROWS][j], b_d[ROWS][j]};
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            sa_pe #(
                .DW    (DW),
                .ACC_W (ACC_W)
            ) u_pe (
                .clk         (clk),
                .rst         (rst),
                .clear       (clear),
                .signed_mode (sm_q),
                .a_in        (a_h[i][j]),
                .a_v_in      (av_h[i][j]),
                .b_in        (b_d[i][j]),
                .b_v_in      (bv_d[i][j]),
                .a_out       (a_h[i][j+1]),
                .a_v_out     (av_h[i][j+1]),
                .b_out       (b_d[i+1][j]),
                .b_v_out     (bv_d[i+1][j]),
                .acc         (acc[i][j])
            );
        end
    end

    logic [ACC_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        if (({1'b0, rd_row} < ROWS_L) && ({1'b0, rd_col} < COLS_L))
            rd_mux = acc[rd_row][rd_col];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else if (rd_en && (state == ST_IDLE)) begin
            rd_valid <= 1'b1;
            rd_data  <= rd_mux;
        end else begin
            rd_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_systolic_array_param.sv
// Directed bench: a 2x2 array for function/latency/protocol and a 3x1 array
// with a narrowed accumulator for wrap and out-of-range reads.
module tb_systolic_array_param;

    localparam int R   = 2;
    localparam int C   = 2;
    localparam int DW  = 8;
    localparam int KM  = 4;
    localparam int AW  = 2 * DW + $clog2(KM) + 1;
    localparam int WR  = 3;
    localparam int WC  = 1;
    localparam int WKM = 2;
    localparam int WAW = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic            start = 0, signed_mode = 0, in_valid = 0, rd_en = 0;
    logic [2:0]      k_len = '0;
    logic [R*DW-1:0] a_col = '0;
    logic [C*DW-1:0] b_row = '0;
    logic            rd_row = 0, rd_col = 0;
    logic            in_ready, busy, done, rd_valid;
    logic [AW-1:0]   rd_data;

    logic             w_start = 0, w_signed_mode = 0, w_in_valid = 0, w_rd_en = 0;
    logic [1:0]       w_k_len = '0;
    logic [WR*DW-1:0] w_a_col = '0;
    logic [WC*DW-1:0] w_b_row = '0;
    logic [1:0]       w_rd_row = '0;
    logic             w_rd_col = 0;
    logic             w_in_ready, w_busy, w_done, w_rd_valid;
    logic [WAW-1:0]   w_rd_data;

    systolic_array_param #(.ROWS(R), .COLS(C), .DW(DW), .K_MAX(KM)) dut (
        .clk(clk), .rst(rst), .start(start), .k_len(k_len), .signed_mode(signed_mode),
        .in_valid(in_valid), .in_ready(in_ready), .a_col(a_col), .b_row(b_row),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .rd_valid(rd_valid), .rd_data(rd_data)
    );

    systolic_array_param #(.ROWS(WR), .COLS(WC), .DW(DW), .K_MAX(WKM), .ACC_W(WAW)) dut_w (
        .clk(clk), .rst(rst), .start(w_start), .k_len(w_k_len), .signed_mode(w_signed_mode),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .a_col(w_a_col), .b_row(w_b_row),
        .busy(w_busy), .done(w_done), .rd_en(w_rd_en), .rd_row(w_rd_row), .rd_col(w_rd_col),
        .rd_valid(w_rd_valid), .rd_data(w_rd_data)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t_start = 0;
    int t_last = 0;
    int t_done = 0;
    int acc_cnt = 0;
    int done_seen = 0;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic rd(input int r, input int c, input logic [31:0] exp, input string tag);
        rd_en  = 1'b1;
        rd_row = r[0];
        rd_col = c[0];
        tick;
        rd_en = 1'b0;
        check({tag, "_vld"}, 32'(rd_valid), 32'd1);
        check(tag, 32'(rd_data), exp);
    endtask

    task automatic wrd(input int r, input int c, input logic [31:0] exp, input string tag);
        w_rd_en  = 1'b1;
        w_rd_row = r[1:0];
        w_rd_col = c[0];
        tick;
        w_rd_en = 1'b0;
        check({tag, "_vld"}, 32'(w_rd_valid), 32'd1);
        check(tag, 32'(w_rd_data), exp);
    endtask

    task automatic start_job(input logic [2:0] k, input logic sm);
        start       = 1'b1;
        k_len       = k;
        signed_mode = sm;
        tick;
        start   = 1'b0;
        t_start = cyc;
    endtask

    task automatic beat(input logic [15:0] a, input logic [15:0] b);
        in_valid = 1'b1;
        a_col    = a;
        b_row    = b;
        tick;
        in_valid = 1'b0;
        t_last   = cyc;
    endtask

    task automatic bubble;
        in_valid = 1'b0;
        a_col    = 16'hFFFF;
        b_row    = 16'hFFFF;
        tick;
    endtask

    // Returns the edge count at which done is first seen; -1000 if it never rises.
    task automatic wait_done(output int t);
        t = -1000;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                t = cyc;
                break;
            end
            tick;
        end
    endtask

    initial begin
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'd0);
        #11 rst = 1'b1;
        tick;

        // 2x2, K=2, unsigned, contiguous beats
        start_job(3'd2, 1'b0);
        check("s1_in_ready", 32'(in_ready), 32'd1);
        check("s1_busy", 32'(busy), 32'd1);
        beat(16'h0301, 16'h0605);
        beat(16'h0402, 16'h0807);
        check("s1_ready_drop", 32'(in_ready), 32'd0);
        wait_done(t_done);
        check("s1_done_lat", 32'(t_done - t_last), 32'd4);
        check("s1_done_from_start", 32'(t_done - t_start), 32'd6);
        check("s1_done_busy", 32'(busy), 32'd0);
        tick;
        check("s1_done_pulse", 32'(done), 32'd0);
        rd(0, 0, 19, "s1_c00");
        rd(0, 1, 22, "s1_c01");
        rd(1, 0, 43, "s1_c10");
        rd(1, 1, 50, "s1_c11");
        tick;
        check("s1_rd_valid_idle", 32'(rd_valid), 32'd0);

        // Signed mode, K=1: a=(-128,127), b=(-128,-1)
        start_job(3'd1, 1'b1);
        beat(16'h7F80, 16'hFF80);
        wait_done(t_done);
        check("sg_done_lat", 32'(t_done - t_last), 32'd4);
        tick;
        rd(0, 0, 16384, "sg_c00");
        rd(0, 1, 128, "sg_c01");
        rd(1, 0, 2**AW - 16256, "sg_c10");
        rd(1, 1, 2**AW - 127, "sg_c11");

        // Same operands unsigned: 128*128, 128*255, 127*128, 127*255
        start_job(3'd1, 1'b0);
        beat(16'h7F80, 16'hFF80);
        wait_done(t_done);
        tick;
        rd(0, 0, 16384, "us_c00");
        rd(0, 1, 32640, "us_c01");
        rd(1, 0, 16256, "us_c10");
        rd(1, 1, 32385, "us_c11");

        // Bubbles between and after beats
        start_job(3'd2, 1'b0);
        beat(16'h0301, 16'h0605);
        bubble;
        bubble;
        beat(16'h0402, 16'h0807);
        bubble;
        wait_done(t_done);
        check("bb_done_from_start", 32'(t_done - t_start), 32'd8);
        check("bb_done_lat", 32'(t_done - t_last), 32'd4);
        tick;
        rd(0, 0, 19, "bb_c00");
        rd(0, 1, 22, "bb_c01");
        rd(1, 0, 43, "bb_c10");
        rd(1, 1, 50, "bb_c11");

        // K=0: done next cycle, results cleared
        start_job(3'd0, 1'b0);
        check("k0_done", 32'(done), 32'd1);
        check("k0_busy", 32'(busy), 32'd0);
        check("k0_in_ready", 32'(in_ready), 32'd0);
        tick;
        check("k0_done_pulse", 32'(done), 32'd0);
        rd(0, 0, 0, "k0_c00");
        rd(1, 1, 0, "k0_c11");

        // k_len=K_MAX+1 clamps to K_MAX beats; in_valid held high throughout
        start_job(3'd5, 1'b0);
        in_valid = 1'b1;
        a_col    = 16'h0101;
        b_row    = 16'h0101;
        acc_cnt  = 0;
        for (int i = 0; i < 6; i++) begin
            if (in_ready) acc_cnt++;
            tick;
        end
        check("cl_beats", 32'(acc_cnt), 32'd4);
        check("cl_ready_drop", 32'(in_ready), 32'd0);
        wait_done(t_done);
        check("cl_done_from_start", 32'(t_done - t_start), 32'd8);
        in_valid = 1'b0;
        tick;
        rd(0, 0, 4, "cl_c00");
        rd(1, 1, 4, "cl_c11");

        // Read and start on the same edge: the read returns the old result
        rd_en  = 1'b1;
        rd_row = 1'b1;
        rd_col = 1'b1;
        start_job(3'd1, 1'b0);
        rd_en = 1'b0;
        check("rs_vld", 32'(rd_valid), 32'd1);
        check("rs_old", 32'(rd_data), 32'd4);
        beat(16'h0302, 16'h0705);
        // start and rd_en during DRAIN are ignored
        start = 1'b1;
        k_len = 3'd0;
        rd_en = 1'b1;
        tick;
        start = 1'b0;
        rd_en = 1'b0;
        check("dr_rd_valid", 32'(rd_valid), 32'd0);
        check("dr_rd_hold", 32'(rd_data), 32'd4);
        check("dr_busy", 32'(busy), 32'd1);
        check("dr_done", 32'(done), 32'd0);
        wait_done(t_done);
        check("dr_done_lat", 32'(t_done - t_last), 32'd4);
        tick;
        rd(0, 0, 10, "dr_c00");
        rd(0, 1, 14, "dr_c01");
        rd(1, 0, 15, "dr_c10");
        rd(1, 1, 21, "dr_c11");

        // Overflow: 255*255 twice, 19-bit accumulator vs. forced 16-bit
        start         = 1'b1;
        k_len         = 3'd2;
        signed_mode   = 1'b0;
        w_start       = 1'b1;
        w_k_len       = 2'd2;
        w_signed_mode = 1'b0;
        tick;
        start   = 1'b0;
        w_start = 1'b0;
        w_in_valid = 1'b1;
        w_a_col    = 24'h0001FF;
        w_b_row    = 8'hFF;
        beat(16'hFFFF, 16'hFFFF);
        beat(16'hFFFF, 16'hFFFF);
        w_in_valid = 1'b0;
        wait_done(t_done);
        check("ov_done_lat", 32'(t_done - t_last), 32'd4);
        check("ov_w_done", 32'(w_done), 32'd1);
        tick;
        rd(0, 0, 130050, "ov_c00_19b");
        rd(1, 1, 130050, "ov_c11_19b");
        wrd(0, 0, 64514, "ov_w_c0_16b");
        wrd(1, 0, 510, "ov_w_c1");
        wrd(2, 0, 0, "ov_w_c2");
        wrd(3, 0, 0, "ov_w_row_oor");
        wrd(0, 1, 0, "ov_w_col_oor");

        // Asynchronous reset in the middle of LOAD
        start_job(3'd2, 1'b0);
        beat(16'h0101, 16'h0101);
        in_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("ar_in_ready", 32'(in_ready), 32'd0);
        check("ar_busy", 32'(busy), 32'd0);
        check("ar_done", 32'(done), 32'd0);
        check("ar_rd_data", 32'(rd_data), 32'd0);
        #3 rst = 1'b1;
        in_valid  = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (done) done_seen++;
        end
        check("ar_no_done", 32'(done_seen), 32'd0);
        rd(0, 0, 0, "ar_c00");
        rd(1, 1, 0, "ar_c11");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
